// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one parallel word per request as start, LSB-first data,
// optional parity and stop bits, one bit per CLK cycle.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            o_dbg_state
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Handshake: Data_Valid is a request that is accepted only on an edge where the
    // FSM is in IDLE; Busy=1 means requests are dropped (no queueing, no error flag).
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;

    state_t                w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_par_en_next;
    logic                  w_parity_next;
    logic                  w_tx_next;
    logic                  w_busy_next;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_par_en <= 1'b0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_data   <= w_data_next;
            r_par_en <= w_par_en_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_busy   <= w_busy_next;
        end
    end

    // Outputs are computed for the state being entered, so TX_OUT/Busy change on that edge.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_data_next   = r_data;
        w_par_en_next = r_par_en;
        w_parity_next = r_parity;
        w_tx_next     = r_tx;
        w_busy_next   = r_busy;
        case (r_state)
            S_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (Data_Valid) begin
                    w_data_next   = P_DATA;
                    w_par_en_next = PAR_EN;
                    w_parity_next = (^P_DATA) ^ PAR_TYP;
                    w_tx_next     = 1'b0;
                    w_busy_next   = 1'b1;
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                w_tx_next    = r_data[0];
                w_busy_next  = 1'b1;
                w_cnt_next   = '0;
                w_state_next = S_DATA;
            end
            S_DATA: begin
                w_busy_next = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    // Counter holds on exit, so it never wraps.
                    if (r_par_en) begin
                        w_tx_next    = r_parity;
                        w_state_next = S_PARITY;
                    end else begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_next = w_cnt_inc;
                    w_tx_next  = r_data[w_cnt_inc];
                end
            end
            S_PARITY: begin
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b1;
                w_state_next = S_STOP;
            end
            S_STOP: begin
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign TX_OUT      = r_tx;
    assign Busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: the driver queues the expected {Busy,TX_OUT} per
// cycle, and a monitor compares one entry per cycle (idle line expected when empty).
module tb_uart_tx_frame;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;
    logic [2:0] o_dbg_state;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [1:0] exp_q[$];

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .TX_OUT      (TX_OUT),
        .Busy        (Busy),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // monitor: one comparison per cycle, #1 after the active edge
    initial begin
        logic [1:0] got;
        logic [1:0] exp_v;
        forever begin
            @(posedge CLK);
            #1;
            cycle++;
            got   = {Busy, TX_OUT};
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b01;
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL line cycle %0d: busy,tx got %b required %b", cycle, got, exp_v);
            end
        end
    end

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic exp_par);
        exp_q.push_back(2'b10);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
        if (pe) exp_q.push_back({1'b1, exp_par});
        exp_q.push_back(2'b11);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d entries left, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic exp_par, input string name);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        push_frame(d, pe, exp_par);
        @(negedge CLK);
        Data_Valid = 1'b0;
        drain(name);
    endtask

    task automatic check_async(input string name);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy,tx got %b%b required 01", name, Busy, TX_OUT);
        end
    endtask

    initial begin
        // reset held with random inputs: line must stay idle
        RST        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            P_DATA     = 8'($urandom_range(0, 255));
            Data_Valid = 1'($urandom_range(0, 1));
            PAR_EN     = 1'($urandom_range(0, 1));
            PAR_TYP    = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        RST        = 1'b1;
        repeat (3) @(negedge CLK);

        // directed frames: data, parity enable, parity type, hand-computed parity bit
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, "a5_nopar");
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5_even");
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, "a5_odd");
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, "07_even");

        // mid-frame input changes, Data_Valid toggled during data and high in STOP
        @(negedge CLK);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        push_frame(8'h3C, 1'b0, 1'b0);
        @(negedge CLK);
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        Data_Valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge CLK);
            Data_Valid = i[0];
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        drain("3c_midframe");

        // back-to-back with Data_Valid held: three frames, one idle bit between each
        @(negedge CLK);
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        push_frame(8'h55, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        push_frame(8'h55, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        push_frame(8'h55, 1'b0, 1'b0);
        repeat (23) @(negedge CLK);
        Data_Valid = 1'b0;
        drain("55_b2b");

        // reset during data bit 4 of 0x6C (bit 4 = 0, so TX_OUT must rise asynchronously)
        @(negedge CLK);
        P_DATA     = 8'h6C;
        Data_Valid = 1'b1;
        exp_q.push_back(2'b10);
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, P_DATA[i]});
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        #1;
        check_async("async_reset");
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, "81_after_reset");

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart of the UART_RX path.
- Accepts a parallel byte with a valid strobe and serialises it LSB-first on TX_OUT as: start bit, data bits, optional parity bit, stop bit.
- CLK is the TX bit clock: one bit per CLK cycle, so no oversampling is done here.
- Sits in the UART block beside UART_RX and is driven by the system-side FIFO/controller.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
CLK  input  1  TX bit clock.
RST  input  1  async active-low reset.
P_DATA  input  DATA_WIDTH  parallel data to transmit.
Data_Valid  input  1  request strobe; sampled only when state is IDLE.
PAR_EN  input  1  1 = insert parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
TX_OUT  output  1  serial line, registered, idles high.
Busy  output  1  high for exactly the frame's bit cycles.

Behaviour:
- One clock domain (CLK). Reset is asynchronous and active-low on RST.
- Reset values: TX_OUT=1, Busy=0, state=IDLE, bit counter=0, data/parity latches=0.
- Reset asserted mid-frame aborts the frame immediately: TX_OUT=1 and Busy=0 with no clock needed. After release the block waits for a new Data_Valid.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered and take the value for a state on the edge that enters that state.
- IDLE:
  - Data_Valid=0: stay in IDLE; TX_OUT=1, Busy=0.
  - Data_Valid=1 at edge k: latch P_DATA, PAR_EN and PAR_TYP; latch parity = ^P_DATA XOR PAR_TYP; go to START. TX_OUT<=0, Busy<=1 at edge k.
- START (1 cycle): go to DATA. TX_OUT<=latched[0], counter<=0.
- DATA (DATA_WIDTH cycles):
  - Each edge: counter increments and TX_OUT<=latched[counter+1].
  - When counter==DATA_WIDTH-1:
    - If PAR_EN latched: go to PARITY, TX_OUT<=parity.
    - Otherwise: go to STOP, TX_OUT<=1.
- PARITY (1 cycle): go to STOP, TX_OUT<=1.
- STOP (1 cycle): go to IDLE. TX_OUT<=1, Busy<=0.
- Frame length with DATA_WIDTH=8: Busy high for 10 cycles (no parity) or 11 cycles (parity), edges k..k+9 or k..k+10.
- Minimum inter-frame gap is one IDLE cycle. Data_Valid is never accepted in STOP, so back-to-back requests give a frame period of 11 or 12 cycles.
- Data_Valid while Busy=1 is ignored: no queueing, no error flag.
- Changes to P_DATA, PAR_EN or PAR_TYP during a frame have no effect on that frame.
- Data_Valid held high continuously: a new frame starts on the first IDLE cycle after each STOP.
- Counter width is clog2(DATA_WIDTH); counter wrap is never reached because the state exits first.

Test Plan:
- Frame, no parity: reset, then P_DATA=0xA5, PAR_EN=0, Data_Valid pulsed 1 cycle → TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1; Busy high for exactly those 10 cycles; then TX_OUT=1, Busy=0.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 → 11-bit frame with parity bit 0. Same data with PAR_TYP=1 → parity bit 1. P_DATA=0x07, PAR_TYP=0 → parity bit 1.
- Mid-frame changes: change P_DATA to 0xFF and toggle Data_Valid during the data bits of a 0x3C frame → 0x3C serialised unchanged; no second frame starts until after STOP plus one IDLE cycle.
- Back-to-back: Data_Valid held high with P_DATA=0x55, PAR_EN=0 → consecutive frames with an 11-cycle period and exactly one TX_OUT=1 idle bit between stop bit and next start bit.
- Reset mid-frame: assert RST during data bit 4 → TX_OUT=1 and Busy=0 asynchronously. After release with Data_Valid=0, TX_OUT stays 1; a new 0x81 request transmits a full correct frame.
- Reset values: hold RST=0 with random inputs → TX_OUT=1, Busy=0 throughout.
